// File: rtl/acc_sched_if.sv
// Handshake and read-port bundle between the row-accumulator issue scheduler and its buffers/sink.
// The stall_cnt member exists only when ACC_SCHED_PERF_EN is defined.
`timescale 1ns/1ps
interface acc_sched_if #(
  parameter int ADDR_W = 12
);
  logic                  start;
  logic                  src_rdy;
  logic                  out_credit;
  logic                  busy;
  logic                  done;
  logic                  ori_re;
  logic [ADDR_W-1:0]     ori_addr;
  logic                  c1_re;
  logic [ADDR_W-1:0]     c1_addr;
  logic [2:0]            c3_re;
  logic [3*ADDR_W-1:0]   c3_addr;
  logic                  out_valid;
  logic [ADDR_W-1:0]     out_addr;
`ifdef ACC_SCHED_PERF_EN
  logic [31:0]           stall_cnt;
`endif

  modport master (
`ifdef ACC_SCHED_PERF_EN
    input  stall_cnt,
`endif
    output start, src_rdy, out_credit,
    input  busy, done, ori_re, ori_addr, c1_re, c1_addr,
    input  c3_re, c3_addr, out_valid, out_addr
  );

  modport slave (
`ifdef ACC_SCHED_PERF_EN
    output stall_cnt,
`endif
    input  start, src_rdy, out_credit,
    output busy, done, ori_re, ori_addr, c1_re, c1_addr,
    output c3_re, c3_addr, out_valid, out_addr
  );
endinterface

// File: rtl/acc_sched.sv
// Issue scheduler for the row accumulator: walks (och,row) pairs, skews buffer reads and meters issue by sink credits.
// Optional ACC_SCHED_PERF_EN adds a stall_cnt counter of RUN cycles without an issue.
`timescale 1ns/1ps
module acc_sched #(
  parameter int ROWS    = 56,
  parameter int OCH     = 64,
  parameter int ADDR_W  = 12,
  parameter int CREDITS = 8
) (
  input logic      clk,
  input logic      rst,
  acc_sched_if.slave bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int OCH_W = (OCH > 1) ? $clog2(OCH) : 1;
  localparam int CRD_W = 5;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [OCH_W-1:0] OCH_LAST = OCH_W'(OCH - 1);
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDITS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Credits never exceed the sink depth; a surplus return is dropped.
  function automatic logic [CRD_W-1:0] sat_credit(input logic [CRD_W-1:0] cur,
                                                  input logic inc, input logic dec);
    logic [CRD_W:0] sum;
    sum = {1'b0, cur} + {{CRD_W{1'b0}}, inc} - {{CRD_W{1'b0}}, dec};
    return (sum > {1'b0, CRD_FULL}) ? CRD_FULL : sum[CRD_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d, row_b;
  logic [OCH_W-1:0]  och_q, och_d, och_b;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_b;
  logic [CRD_W-1:0]  credit_q, credit_d, credit_b;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              can_start, issue;
  // Index n of the pipe is the stage n cycles after the ori_re cycle.
  logic [5:0]        vld_p_q, vld_p_d;
  logic [ADDR_W-1:0] addr_p_q [6];
  logic [ADDR_W-1:0] addr_p_d [6];
`ifdef ACC_SCHED_PERF_EN
  logic [31:0]       stall_q, stall_d;
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    done_d    = 1'b0;
    can_start = (state_q == IDLE) && !done_q && bus.start;
    row_b     = can_start ? '0 : row_q;
    och_b     = can_start ? '0 : och_q;
    addr_b    = can_start ? '0 : addr_q;
    credit_b  = can_start ? CRD_FULL : credit_q;
    if (can_start) last_d = 1'b0;
    issue = (can_start && bus.src_rdy) ||
            ((state_q == RUN) && !last_q && bus.src_rdy && ((credit_q != '0) || bus.out_credit));
    credit_d = sat_credit(credit_b, bus.out_credit && !can_start, issue);
    row_d  = row_b;
    och_d  = och_b;
    addr_d = addr_b;
    if (issue) begin
      addr_d = addr_b + ADDR_W'(1);
      if (row_b == ROW_LAST) begin
        row_d = '0;
        if (och_b == OCH_LAST) last_d = 1'b1;
        else                   och_d  = och_b + OCH_W'(1);
      end else begin
        row_d = row_b + ROW_W'(1);
      end
    end
    vld_p_d     = {vld_p_q[4:0], issue};
    addr_p_d[0] = issue ? addr_b : addr_p_q[0];
    for (int i = 1; i < 6; i++) addr_p_d[i] = addr_p_q[i-1];
    case (state_q)
      IDLE:    if (can_start) state_d = RUN;
      RUN:     if (last_q) state_d = DRAIN;
      DRAIN:   if (vld_p_q[4:0] == '0) begin
                 state_d = IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = IDLE;
    endcase
    // busy stays up through the done cycle so a start there is still ignored.
    busy_d = (state_d != IDLE) || done_d;
`ifdef ACC_SCHED_PERF_EN
    stall_d = can_start ? 32'd0
            : stall_q + (((state_q == RUN) && !vld_p_q[0]) ? 32'd1 : 32'd0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      och_q    <= '0;
      addr_q   <= '0;
      credit_q <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vld_p_q  <= '0;
      for (int i = 0; i < 6; i++) addr_p_q[i] <= '0;
`ifdef ACC_SCHED_PERF_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      och_q    <= och_d;
      addr_q   <= addr_d;
      credit_q <= credit_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      vld_p_q  <= vld_p_d;
      for (int i = 0; i < 6; i++) addr_p_q[i] <= addr_p_d[i];
`ifdef ACC_SCHED_PERF_EN
      stall_q  <= stall_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ori_re    = vld_p_q[0];
  assign bus.ori_addr  = addr_p_q[0];
  assign bus.c1_re     = vld_p_q[1];
  assign bus.c1_addr   = addr_p_q[1];
  assign bus.c3_re     = vld_p_q[3:1];
  assign bus.c3_addr   = {addr_p_q[3], addr_p_q[2], addr_p_q[1]};
  assign bus.out_valid = vld_p_q[5];
  assign bus.out_addr  = addr_p_q[5];
`ifdef ACC_SCHED_PERF_EN
  assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_acc_sched.sv
// Directed bench for acc_sched: two instances (8 and 2 credits), per-cycle expectations from a stimulus plan
// and a scoreboard of output addresses.
`timescale 1ns/1ps
module tb_acc_sched;
  localparam int AW   = 12;
  localparam int ROWS = 4;
  localparam int OCH  = 2;
  localparam int N    = ROWS * OCH;
  localparam int MAXK = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_sched_if #(.ADDR_W(AW)) a_if ();
  acc_sched_if #(.ADDR_W(AW)) b_if ();

  acc_sched #(.ROWS(ROWS), .OCH(OCH), .ADDR_W(AW), .CREDITS(8)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  acc_sched #(.ROWS(ROWS), .OCH(OCH), .ADDR_W(AW), .CREDITS(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));

  int   total = 0;
  int   bad   = 0;
  logic ei  [MAXK];
  int   ea  [MAXK];
  logic rdy [MAXK];
  logic crd [MAXK];
  int   sb  [$];
  int   L;
  int   exp_stall;

  logic            o_ori_re, o_c1_re, o_ov, o_busy, o_done;
  logic [2:0]      o_c3_re;
  logic [AW-1:0]   o_ori_addr, o_c1_addr, o_oa;
  logic [3*AW-1:0] o_c3_addr;
  logic [31:0]     o_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic r, input logic c);
    a_if.start = 1'b0; a_if.src_rdy = 1'b0; a_if.out_credit = 1'b0;
    b_if.start = 1'b0; b_if.src_rdy = 1'b0; b_if.out_credit = 1'b0;
    if (sel == 0) begin
      a_if.start = st; a_if.src_rdy = r; a_if.out_credit = c;
    end else begin
      b_if.start = st; b_if.src_rdy = r; b_if.out_credit = c;
    end
  endtask

  task automatic snap(input int sel);
    if (sel == 0) begin
      o_ori_re = a_if.ori_re; o_ori_addr = a_if.ori_addr; o_c1_re = a_if.c1_re; o_c1_addr = a_if.c1_addr;
      o_c3_re = a_if.c3_re; o_c3_addr = a_if.c3_addr; o_ov = a_if.out_valid; o_oa = a_if.out_addr;
      o_busy = a_if.busy; o_done = a_if.done;
`ifdef ACC_SCHED_PERF_EN
      o_stall = a_if.stall_cnt;
`else
      o_stall = '0;
`endif
    end else begin
      o_ori_re = b_if.ori_re; o_ori_addr = b_if.ori_addr; o_c1_re = b_if.c1_re; o_c1_addr = b_if.c1_addr;
      o_c3_re = b_if.c3_re; o_c3_addr = b_if.c3_addr; o_ov = b_if.out_valid; o_oa = b_if.out_addr;
      o_busy = b_if.busy; o_done = b_if.done;
`ifdef ACC_SCHED_PERF_EN
      o_stall = b_if.stall_cnt;
`else
      o_stall = '0;
`endif
    end
  endtask

  function automatic logic eiv(input int i);
    return (i < 0 || i >= MAXK) ? 1'b0 : ei[i];
  endfunction

  // Expected issue cycles/addresses from the src_rdy/out_credit plan (cycle 0 = start cycle).
  task automatic plan(input int cred, input logic auto_ret);
    int   cnt, cr;
    logic iss;
    for (int i = 0; i < MAXK; i++) begin ei[i] = 1'b0; ea[i] = 0; end
    cnt = 0; cr = cred; L = 0;
    for (int k = 0; k < MAXK - 1; k++) begin
      if (auto_ret) crd[k] = (k == 0) ? 1'b0 : eiv(k - 5);
      if (k == 0) begin
        iss = rdy[0];
        cr  = cred - int'(iss);
      end else begin
        iss = rdy[k] && (cnt < N) && (cr + int'(crd[k]) > 0);
        cr  = cr + int'(crd[k]) - int'(iss);
        if (cr > cred) cr = cred;
      end
      if (iss) begin
        ei[k+1] = 1'b1; ea[k+1] = cnt; cnt++; L = k + 1;
      end
    end
    exp_stall = 0;
    for (int k = 1; k <= L; k++) if (!ei[k]) exp_stall++;
  endtask

  task automatic check_cycle(input int sel, input int k);
    int e;
    snap(sel);
    chk($sformatf("ori_re@%0d", k), o_ori_re, eiv(k));
    if (eiv(k)) chk($sformatf("ori_addr@%0d", k), o_ori_addr, ea[k]);
    chk($sformatf("c1_re@%0d", k), o_c1_re, eiv(k-1));
    if (eiv(k-1)) chk($sformatf("c1_addr@%0d", k), o_c1_addr, ea[k-1]);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("c3_re[%0d]@%0d", j, k), o_c3_re[j], eiv(k-1-j));
      if (eiv(k-1-j)) chk($sformatf("c3_addr[%0d]@%0d", j, k), o_c3_addr[j*AW +: AW], ea[k-1-j]);
    end
    chk($sformatf("out_valid@%0d", k), o_ov, eiv(k-5));
    if (o_ov) begin
      if (sb.size() == 0) chk($sformatf("sb_underflow@%0d", k), o_ov, 1'b0);
      else begin
        e = sb.pop_front();
        chk($sformatf("out_addr@%0d", k), o_oa, e);
      end
    end
    chk($sformatf("busy@%0d", k), o_busy, (k >= 1) && (k <= L + 6));
    chk($sformatf("done@%0d", k), o_done, k == L + 6);
  endtask

  task automatic run_tile(input int sel, input int cred, input logic auto_ret, input int extra_start);
    plan(cred, auto_ret);
    for (int k = 0; k <= L + 6; k++) begin
      drive(sel, (k == 0) || (k == extra_start), rdy[k], crd[k]);
      if (ei[k+1]) sb.push_back(ea[k+1]);
      tick();
      check_cycle(sel, k + 1);
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
    chk("sb_drained", sb.size(), 0);
`ifdef ACC_SCHED_PERF_EN
    snap(sel);
    chk("stall_cnt", o_stall, exp_stall);
`endif
  endtask

  task automatic set_rdy_all(input logic v);
    for (int i = 0; i < MAXK; i++) begin rdy[i] = v; crd[i] = 1'b0; end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      snap(s);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_ori_re", o_ori_re, 1'b0);
      chk("rst_c3_re", o_c3_re, 3'b000);
      chk("rst_out_valid", o_ov, 1'b0);
      chk("rst_out_addr", o_oa, '0);
    end
    rst = 1'b0;
    tick();

    // Free-running tile, credit returned per out_valid.
    set_rdy_all(1'b1);
    run_tile(0, 8, 1'b1, -1);

    // Source pause of 3 cycles, plus a start pulse while busy.
    set_rdy_all(1'b1);
    rdy[5] = 1'b0; rdy[6] = 1'b0; rdy[7] = 1'b0;
    run_tile(0, 8, 1'b1, 3);

    // Address 5 issued in isolation for a clean skew pattern.
    set_rdy_all(1'b1);
    rdy[5] = 1'b0; rdy[6] = 1'b0; rdy[7] = 1'b0;
    rdy[9] = 1'b0; rdy[10] = 1'b0; rdy[11] = 1'b0;
    run_tile(0, 8, 1'b1, -1);

    // Two credits: saturation, exhaustion, single-pulse reissue, simultaneous issue + return.
    set_rdy_all(1'b1);
    for (int i = 0; i < 4; i++) rdy[i] = 1'b0;
    for (int i = 11; i <= 15; i++) rdy[i] = 1'b0;
    crd[1] = 1'b1; crd[2] = 1'b1; crd[9] = 1'b1; crd[15] = 1'b1; crd[16] = 1'b1;
    for (int i = 20; i < MAXK; i++) crd[i] = 1'b1;
    run_tile(1, 2, 1'b0, -1);

    // Reset with three rows in flight, then a clean restart.
    set_rdy_all(1'b1);
    plan(8, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(0, k == 0, 1'b1, 1'b0);
      tick();
      check_cycle(0, k + 1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    snap(0);
    chk("rstmid_out_valid", o_ov, 1'b0);
    chk("rstmid_busy", o_busy, 1'b0);
    chk("rstmid_ori_re", o_ori_re, 1'b0);
    chk("rstmid_c3_re", o_c3_re, 3'b000);
    for (int k = 0; k < 8; k++) begin
      tick();
      snap(0);
      chk($sformatf("rstmid_ov+%0d", k), o_ov, 1'b0);
      chk($sformatf("rstmid_done+%0d", k), o_done, 1'b0);
    end
    sb.delete();
    set_rdy_all(1'b1);
    run_tile(0, 8, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acc_sched.md
# acc_sched

Issue scheduler for the row accumulator. It walks every (output channel, row) pair of a tile and drives skewed read enables and addresses into the original, conv1 and conv3 partial-sum buffers, so that each operand arrives at the accumulator on its required edge. It also generates the aligned `out_valid`/`out_addr` for the sink and throttles issue with a credit counter, because the accumulator pipeline has no stall input.

## Interface
Parameters:
- `ROWS`, 56: rows per output channel.
- `OCH`, 64: output channels per tile.
- `ADDR_W`, 12: buffer/sink address width; must be ≥ clog2(ROWS*OCH).
- `CREDITS`, 8: sink entries available at start; must be ≥ 1 and < 16.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins a tile. Accepted only in IDLE.
- `src_rdy` in 1: all operand buffers hold valid data for the current issue.
- `out_credit` in 1: pulse; the sink freed one entry.
- `busy` out 1: high when state is not IDLE.
- `done` out 1: one-cycle pulse at tile completion.
- `ori_re` out 1, `ori_addr` out ADDR_W: original-path read.
- `c1_re` out 1, `c1_addr` out ADDR_W: conv1 read.
- `c3_re` out 3, `c3_addr` out 3*ADDR_W: conv3 slice k read, with address in field k.
- `out_valid` out 1, `out_addr` out ADDR_W: the accumulator output is valid for this address.
- `stall_cnt` out 32: present only with `ACC_SCHED_PERF_EN`.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on `start`.
  - RUN → DRAIN in the cycle after the last issue (och=OCH-1, row=ROWS-1).
  - DRAIN → IDLE when the in-flight pipe is empty. `done` pulses in that cycle.
- Issue happens in RUN when `src_rdy`=1 and credit>0.
  - Issue address = och*ROWS + row. Keep it as a running counter; do not use a multiplier.
  - On issue, row increments. It wraps to 0 at ROWS-1 and then och increments.
- Operand skew, for a row issued in cycle T (buffers have 1-cycle read latency):
  - `ori_re` at T.
  - `c1_re` at T+1.
  - `c3_re[0]` at T+1, `c3_re[1]` at T+2, `c3_re[2]` at T+3.
  - All addresses equal the issue address.
  - Implement as a 5-deep valid/address shift register. Back-to-back issues overlap freely; every stage carries its own address.
- Output: `out_valid`=1 and `out_addr`=issue address at T+5.
- Credit counter:
  - Loaded with CREDITS on `start`.
  - −1 on issue, +1 on `out_credit`.
  - Both in the same cycle: net unchanged.
  - The counter saturates at CREDITS. An excess `out_credit` is ignored.
- `start` while busy is ignored.
- `src_rdy` or credit dropping mid-row pauses issue only. In-flight rows still complete.
- All outputs reset to 0. `rst` mid-tile clears the FSM, counters and shift register; `out_valid` is 0 in the cycle after `rst`. In-flight rows are dropped and no `done` is produced.

## Timing
- Latency from issue to `out_valid`: 5 cycles.
- Peak throughput: 1 row/cycle.
- With `src_rdy` held high and sufficient credits, the first `ori_re` is at `start`+1.
- Tile time is ROWS*OCH + 5 cycles plus stall cycles.
- `done` coincides with the final `out_valid` cycle + 1.
- `busy` rises in the cycle after `start` and falls in the cycle after `done`.
- All outputs are registered.

## Configuration
- `ACC_SCHED_PERF_EN` defined:
  - `stall_cnt` port exists.
  - It counts RUN cycles with no issue.
  - It clears on `start` or `rst` and holds its value in IDLE.
- `ACC_SCHED_PERF_EN` undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Test plan
- **Free-running tile:** ROWS=4, OCH=2, CREDITS=8, `src_rdy`=1, sink returns a credit per `out_valid`.
  - 8 issues on consecutive cycles.
  - `out_addr` runs 0..7 from `start`+6 to `start`+13.
  - `done` at `start`+14.
- **Skew check:**
  - Issue at T with address 5 → `c1_addr`=5 at T+1.
  - `c3_re` pattern 001/010/100 at T+1/T+2/T+3, with `c3_addr` field k=5.
  - `out_valid` at T+5.
- **Credit exhaustion:** CREDITS=2 and no `out_credit` → exactly 2 issues, then stall; `out_credit` pulse → one further issue exactly one cycle later.
- **Simultaneous events:** issue and `out_credit` in the same cycle → credit unchanged. `out_credit` at full credit → credit stays at CREDITS.
- **Source pause:** `src_rdy` low for 3 cycles mid-tile → 3-cycle gap in issue, no address skipped or duplicated. With `ACC_SCHED_PERF_EN` defined, `stall_cnt`=3.
- **Reset mid-operation:**
  - `rst` with 3 rows in flight → `out_valid`=0 from the next cycle, `busy`=0, no `done`.
  - A subsequent `start` restarts from address 0.
